// File: rtl/r4_twiddle_mult_pkg.sv
// Shared IFFT datapath constants, result type and Q-format helpers for the
// radix-4 twiddle stage.
package ifft_pkg;
  localparam int WIDTH     = 26;
  localparam int TW_WIDTH  = 16;
  localparam int N         = 2048;
  localparam int ADDR_W    = 12;
  localparam int FRAME_LEN = 256;

  localparam int LOG2N    = $clog2(N);
  localparam int M_W      = LOG2N - 2;
  localparam int ROM_AW   = LOG2N - 1;
  localparam int ROM_DEPTH = N / 4 + 1;
  localparam int PROD_W   = WIDTH + TW_WIDTH;
  localparam int SUM_W    = PROD_W + 1;
  localparam int TW_SHIFT = TW_WIDTH - 2;
  localparam int TW_ONE   = 1 << TW_SHIFT;
  localparam int CNT_W    = $clog2(FRAME_LEN);

  localparam logic signed [SUM_W-1:0] RND_CONST = SUM_W'(1) <<< (TW_WIDTH - 3);

  typedef struct packed {
    logic                    sat;
    logic signed [WIDTH-1:0] val;
  } sat_res_t;

  function automatic logic signed [SUM_W-1:0] sat_hi();
    sat_hi = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic logic signed [SUM_W-1:0] sat_lo();
    sat_lo = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  endfunction

  // round(TW_ONE*cos(2*pi*j/N)) at elaboration time; Q60 Taylor series keeps
  // the error far below the half-LSB rounding decision.
  function automatic logic signed [TW_WIDTH-1:0] tw_cos(input int j);
    logic signed [127:0] pi_q, x, x2, term, acc, res;
    pi_q = 128'sh3243F6A8885A308D;
    x    = (pi_q * 128'sd2 * 128'(j)) / 128'(N);
    x2   = (x * x) >>> 60;
    term = 128'sd1 <<< 60;
    acc  = term;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x2) >>> 60;
      term = -term / 128'(2 * n * (2 * n - 1));
      acc  = acc + term;
    end
    res = (acc * 128'(TW_ONE) + (128'sd1 <<< 59)) >>> 60;
    return res[TW_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/r4_twiddle_mult_if.sv
// Streaming sample bus between the radix-4 butterfly and the twiddle multiplier.
interface r4_twiddle_mult_if;
  import ifft_pkg::*;

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_r;
  logic signed [WIDTH-1:0] in_i;
  logic [ADDR_W-1:0]       tw_addr;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_r;
  logic signed [WIDTH-1:0] out_i;
  logic                    sat_flag;
  logic                    frame_done;

  modport master (
    output in_valid, in_r, in_i, tw_addr,
    input  out_valid, out_r, out_i, sat_flag, frame_done
  );

  modport slave (
    input  in_valid, in_r, in_i, tw_addr,
    output out_valid, out_r, out_i, sat_flag, frame_done
  );
endinterface

// File: rtl/r4_twiddle_mult_rom.sv
// Quarter-wave cosine table, N/4+1 entries, two synchronous read ports.
module twiddle_rom
  import ifft_pkg::*;
(
  input  logic                       clk,
  input  logic [ROM_AW-1:0]          addr_a_i,
  input  logic [ROM_AW-1:0]          addr_b_i,
  output logic signed [TW_WIDTH-1:0] data_a_o,
  output logic signed [TW_WIDTH-1:0] data_b_o
);
  logic signed [TW_WIDTH-1:0] rom [ROM_DEPTH];
  logic signed [TW_WIDTH-1:0] rd_a_q, rd_b_q;

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic signed [TW_WIDTH-1:0] CV = tw_cos(g);
    assign rom[g] = CV;
  end

  always_ff @(posedge clk) begin
    rd_a_q <= rom[addr_a_i];
    rd_b_q <= rom[addr_b_i];
  end

  assign data_a_o = rd_a_q;
  assign data_b_o = rd_b_q;
endmodule

// File: rtl/r4_twiddle_mult.sv
// Multiplies the butterfly output stream by exp(+j*2*pi*k/N) with 3-cycle latency,
// half-up rounding, saturation and a per-frame completion pulse.
module r4_twiddle_mult
  import ifft_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  r4_twiddle_mult_if.slave io_if
);
  logic [LOG2N-1:0]           k_mod;
  logic [ROM_AW-1:0]          addr_c, addr_s;
  logic signed [TW_WIDTH-1:0] cm_p1, cmp_p1, c_p1, s_p1;
  logic [1:0]                 quad_p1_q;
  logic signed [WIDTH-1:0]    dr_p1_q, di_p1_q;
  logic                       vld_p1_q, vld_p2_q;
  logic signed [PROD_W-1:0]   rc_p2_q, is_p2_q, rs_p2_q, ic_p2_q;
  logic signed [SUM_W-1:0]    re_sum, im_sum;
  sat_res_t                   res_re, res_im;
  logic signed [WIDTH-1:0]    out_r_d, out_r_q, out_i_d, out_i_q;
  logic                       sat_d, sat_q, fd_d, fd_q, ovld_d, ovld_q;
  logic [CNT_W-1:0]           cnt_d, cnt_q;

  function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] x);
    return (x + RND_CONST) >>> TW_SHIFT;
  endfunction

  function automatic sat_res_t saturate(input logic signed [SUM_W-1:0] x);
    sat_res_t                r;
    logic signed [SUM_W-1:0] hi, lo;
    hi = sat_hi();
    lo = sat_lo();
    r.sat = 1'b1;
    if (x > hi)      r.val = hi[WIDTH-1:0];
    else if (x < lo) r.val = lo[WIDTH-1:0];
    else begin
      r.sat = 1'b0;
      r.val = x[WIDTH-1:0];
    end
    return r;
  endfunction

  // S1: exponent folded into quadrant + quarter-wave index; ROM read is the stage register
  assign k_mod  = LOG2N'({1'b0, io_if.tw_addr} % (ADDR_W+1)'(N));
  assign addr_c = ROM_AW'(k_mod[M_W-1:0]);
  assign addr_s = ROM_AW'(N / 4) - addr_c;

  twiddle_rom u_rom (
    .clk      (clk),
    .addr_a_i (addr_c),
    .addr_b_i (addr_s),
    .data_a_o (cm_p1),
    .data_b_o (cmp_p1)
  );

  always_ff @(posedge clk) begin
    quad_p1_q <= k_mod[LOG2N-1 -: 2];
    dr_p1_q   <= io_if.in_r;
    di_p1_q   <= io_if.in_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= io_if.in_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  always_comb begin
    c_p1 = cm_p1;
    s_p1 = cmp_p1;
    case (quad_p1_q)
      2'd1:    begin c_p1 = -cmp_p1; s_p1 =  cm_p1;  end
      2'd2:    begin c_p1 = -cm_p1;  s_p1 = -cmp_p1; end
      2'd3:    begin c_p1 =  cmp_p1; s_p1 = -cm_p1;  end
      default: begin c_p1 =  cm_p1;  s_p1 =  cmp_p1; end
    endcase
  end

  // S2: four real products
  always_ff @(posedge clk) begin
    rc_p2_q <= PROD_W'(dr_p1_q) * PROD_W'(c_p1);
    is_p2_q <= PROD_W'(di_p1_q) * PROD_W'(s_p1);
    rs_p2_q <= PROD_W'(dr_p1_q) * PROD_W'(s_p1);
    ic_p2_q <= PROD_W'(di_p1_q) * PROD_W'(c_p1);
  end

  // S3: combine, round, saturate; outputs hold between valid samples
  always_comb begin
    re_sum  = SUM_W'(rc_p2_q) - SUM_W'(is_p2_q);
    im_sum  = SUM_W'(rs_p2_q) + SUM_W'(ic_p2_q);
    res_re  = saturate(round_shift(re_sum));
    res_im  = saturate(round_shift(im_sum));
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    ovld_d  = vld_p2_q;
    if (vld_p2_q) begin
      out_r_d = res_re.val;
      out_i_d = res_im.val;
      sat_d   = res_re.sat | res_im.sat;
      fd_d    = (cnt_q == CNT_W'(FRAME_LEN - 1));
      cnt_d   = fd_d ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r_q <= '0;
      out_i_q <= '0;
      sat_q   <= 1'b0;
      fd_q    <= 1'b0;
      ovld_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      sat_q   <= sat_d;
      fd_q    <= fd_d;
      ovld_q  <= ovld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io_if.out_valid  = ovld_q;
  assign io_if.out_r      = out_r_q;
  assign io_if.out_i      = out_i_q;
  assign io_if.sat_flag   = sat_q;
  assign io_if.frame_done = fd_q;
endmodule

// File: tb/tb_r4_twiddle_mult.sv
// Randomised bench for r4_twiddle_mult against a floating-point rotation model.
module tb_r4_twiddle_mult;
  import ifft_pkg::*;

  typedef struct {
    bit     v;
    longint r, i;
    int     k;
    bit     lit;
    longint lr, li;
    bit     ls;
  } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  r4_twiddle_mult_if io_if ();

  r4_twiddle_mult dut (
    .clk   (clk),
    .rst   (rst),
    .io_if (io_if)
  );

  int     n_vec = 0, n_err = 0, cyc = 0, fd_seen = 0;
  samp_t  hist[4];
  longint m_r = 0, m_i = 0;
  bit     m_sat = 1'b0;
  int     m_cnt = 0;

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic longint rnd_real(input real x);
    if (x >= 0.0) return longint'($floor(x + 0.5));
    return -longint'($floor(-x + 0.5));
  endfunction

  // Ideal rotation with the twiddle quantised to TW_WIDTH bits, then round/saturate.
  function automatic void model(input longint r, input longint i, input int k,
                                output longint yr, output longint yi, output bit sat);
    real    th;
    longint c, s, pr, pq, hi, lo;
    th = 2.0 * 3.14159265358979323846 * real'(k % N) / real'(N);
    c  = rnd_real(real'(TW_ONE) * $cos(th));
    s  = rnd_real(real'(TW_ONE) * $sin(th));
    pr = (r * c - i * s + (longint'(1) << (TW_WIDTH - 3))) >>> (TW_WIDTH - 2);
    pq = (r * s + i * c + (longint'(1) << (TW_WIDTH - 3))) >>> (TW_WIDTH - 2);
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    sat = 1'b0;
    yr = pr;
    yi = pq;
    if (pr > hi) begin yr = hi; sat = 1'b1; end
    if (pr < lo) begin yr = lo; sat = 1'b1; end
    if (pq > hi) begin yi = hi; sat = 1'b1; end
    if (pq < lo) begin yi = lo; sat = 1'b1; end
  endfunction

  function automatic longint rand_data();
    logic signed [WIDTH-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = {1'b1, {(WIDTH-1){1'b0}}};
      1:       v = {1'b0, {(WIDTH-1){1'b1}}};
      default: v = WIDTH'($urandom);
    endcase
    return longint'(v);
  endfunction

  task automatic check_outputs();
    samp_t  e;
    longint yr, yi;
    bit     ys, fd;
    e  = hist[(cyc + 1) % 4];
    fd = 1'b0;
    if (e.v) begin
      model(e.r, e.i, e.k, yr, yi, ys);
      m_r   = yr;
      m_i   = yi;
      m_sat = ys;
      fd    = (m_cnt == FRAME_LEN - 1);
      m_cnt = (m_cnt + 1) % FRAME_LEN;
    end
    if (io_if.frame_done === 1'b1) fd_seen++;
    chk("out_valid", io_if.out_valid, e.v);
    chk("out_r", io_if.out_r, m_r);
    chk("out_i", io_if.out_i, m_i);
    chk("sat_flag", io_if.sat_flag, m_sat);
    chk("frame_done", io_if.frame_done, fd);
    if (e.v && e.lit) begin
      chk("dir_out_r", io_if.out_r, e.lr);
      chk("dir_out_i", io_if.out_i, e.li);
      chk("dir_sat", io_if.sat_flag, e.ls);
    end
  endtask

  task automatic step(input bit v, input longint r, input longint i, input int k,
                      input bit lit, input longint lr, input longint li, input bit ls);
    check_outputs();
    io_if.in_valid = v;
    io_if.in_r     = WIDTH'(r);
    io_if.in_i     = WIDTH'(i);
    io_if.tw_addr  = ADDR_W'(k);
    hist[cyc % 4]  = '{v, r, i, k, lit, lr, li, ls};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, rand_data(), rand_data(), int'($urandom_range(0, 4095)), 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drive(input longint r, input longint i, input int k);
    step(1'b1, r, i, k, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drive_lit(input longint r, input longint i, input int k,
                           input longint lr, input longint li, input bit ls);
    step(1'b1, r, i, k, 1'b1, lr, li, ls);
  endtask

  task automatic do_reset();
    check_outputs();
    rst = 1'b0;
    io_if.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", io_if.out_valid, 0);
    chk("rst_out_r", io_if.out_r, 0);
    chk("rst_out_i", io_if.out_i, 0);
    chk("rst_sat_flag", io_if.sat_flag, 0);
    chk("rst_frame_done", io_if.frame_done, 0);
    for (int j = 0; j < 4; j++) hist[j].v = 1'b0;
    m_r = 0; m_i = 0; m_sat = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
  endtask

  initial begin
    longint r, i;
    int     k, q, sent;
    io_if.in_valid = 1'b0;
    io_if.in_r     = '0;
    io_if.in_i     = '0;
    io_if.tw_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", io_if.out_valid, 0);
    chk("init_out_r", io_if.out_r, 0);
    chk("init_out_i", io_if.out_i, 0);
    chk("init_sat_flag", io_if.sat_flag, 0);
    chk("init_frame_done", io_if.frame_done, 0);
    rst = 1'b1;

    drive_lit(1000, -500, 0, 1000, -500, 1'b0);
    drive_lit(1000, -500, 512, 500, 1000, 1'b0);
    drive_lit(1000, -500, 1024, -1000, 500, 1'b0);
    drive_lit(1000, -500, 1536, -500, -1000, 1'b0);
    drive_lit(16384, 0, 256, 11585, 11585, 1'b0);
    drive_lit(33554431, 33554431, 256, 0, 33554431, 1'b1);
    drive_lit(16384, 0, 1, 16384, 50, 1'b0);
    drive_lit(16384, 0, 2047, 16384, -50, 1'b0);

    // Quarter-turn exponents (including ones past N-1) rotate bit-exactly.
    for (int n = 0; n < 24; n++) begin
      r = longint'($urandom_range(0, 67108862)) - 33554431;
      i = longint'($urandom_range(0, 67108862)) - 33554431;
      q = int'($urandom_range(0, 3));
      k = q * (N / 4) + int'($urandom_range(0, 1)) * N;
      case (q)
        0:       drive_lit(r, i, k, r, i, 1'b0);
        1:       drive_lit(r, i, k, -i, r, 1'b0);
        2:       drive_lit(r, i, k, -r, -i, 1'b0);
        default: drive_lit(r, i, k, i, -r, 1'b0);
      endcase
      if ($urandom_range(0, 2) == 0) idle();
    end
    repeat (3) idle();

    do_reset();
    fd_seen = 0;
    sent = 0;
    while (sent < FRAME_LEN) begin
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        drive(rand_data(), rand_data(), sent);
        sent++;
      end
    end
    repeat (4) idle();
    chk("frame_pulses", fd_seen, 1);

    for (int n = 0; n < 5; n++) drive(rand_data(), rand_data(), int'($urandom_range(0, 4095)));
    do_reset();
    fd_seen = 0;
    sent = 0;
    while (sent < FRAME_LEN) begin
      if ($urandom_range(0, 4) == 0) idle();
      else begin
        drive(rand_data(), rand_data(), int'($urandom_range(0, 4095)));
        sent++;
      end
    end
    repeat (4) idle();
    chk("frame_pulses_after_rst", fd_seen, 1);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else drive(rand_data(), rand_data(), int'($urandom_range(0, 4095)));
    end
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
